fcl1_sram_rsp: RTL and testbench

// SRAM responder for the FCL layer-1 control path. Accepts the write/read enables and

---
 rtl/fcl1_sram_rsp_if.sv | 34 +++
 rtl/fcl1_sram_rsp.sv | 179 +++++++++++++++++
 tb/tb_fcl1_sram_rsp.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fcl1_sram_rsp_if.sv
// Request/response bundle between the FCL1 controller and its SRAM responder.
interface fcl1_sram_rsp_if #(
  parameter int SRAM_CNT_WIDTH = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 5,
  parameter int FILT_CNT_WIDTH = 7
);
  logic                          fcl_rsp_clr_i;
  logic                          fcl_rsp_sram_wr_en_i;
  logic                          fcl_rsp_sram_rd_en_i;
  logic [SRAM_CNT_WIDTH-1:0]     fcl_rsp_sram_addr_i;
  logic [DATA_WIDTH-1:0]         fcl_rsp_wr_data_i;
  logic [DATA_WIDTH-1:0]         fcl_rsp_rd_data_o;
  logic                          fcl_rsp_rd_valid_o;
  logic [DATA_WIDTH*DEPTH-1:0]   fcl_rsp_vec_o;
  logic                          fcl_rsp_vec_valid_o;
  logic [FILT_CNT_WIDTH-1:0]     fcl_rsp_filt_cnt_o;
  logic                          fcl_rsp_all_done_o;
  logic                          fcl_rsp_err_o;

  modport master (
    output fcl_rsp_clr_i, fcl_rsp_sram_wr_en_i, fcl_rsp_sram_rd_en_i,
           fcl_rsp_sram_addr_i, fcl_rsp_wr_data_i,
    input  fcl_rsp_rd_data_o, fcl_rsp_rd_valid_o, fcl_rsp_vec_o, fcl_rsp_vec_valid_o,
           fcl_rsp_filt_cnt_o, fcl_rsp_all_done_o, fcl_rsp_err_o
  );

  modport slave (
    input  fcl_rsp_clr_i, fcl_rsp_sram_wr_en_i, fcl_rsp_sram_rd_en_i,
           fcl_rsp_sram_addr_i, fcl_rsp_wr_data_i,
    output fcl_rsp_rd_data_o, fcl_rsp_rd_valid_o, fcl_rsp_vec_o, fcl_rsp_vec_valid_o,
           fcl_rsp_filt_cnt_o, fcl_rsp_all_done_o, fcl_rsp_err_o
  );
endinterface

// File: rtl/fcl1_sram_rsp.sv
// SRAM responder for the FCL1 control path: local weight store, burst-order checker,
// read-burst packer and per-frame filter counter.
module fcl1_sram_rsp #(
  parameter int SRAM_CNT_WIDTH = 3,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 5,
  parameter int NUM_FILT       = 120,
  parameter int FILT_CNT_WIDTH = 7
) (
  input  logic             fcl_ctrl_clk,
  input  logic             fcl_ctrl_rst,
  fcl1_sram_rsp_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [SRAM_CNT_WIDTH-1:0] LAST_ADDR    = SRAM_CNT_WIDTH'(DEPTH - 1);
  localparam logic [FILT_CNT_WIDTH-1:0] FILT_LAST_M1 = FILT_CNT_WIDTH'(NUM_FILT - 1);

  logic                        clr;
  logic                        wr;
  logic                        rd;
  logic [SRAM_CNT_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]       wr_data;

  state_t                      state;
  state_t                      state_nxt;
  logic [SRAM_CNT_WIDTH-1:0]   exp;
  logic [SRAM_CNT_WIDTH-1:0]   exp_nxt;

  logic                        do_wr;
  logic                        do_rd;
  logic                        burst_rd_done;
  logic                        err_set;
  logic                        in_range;
  logic                        dir_switch;

  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_valid;
  logic [DATA_WIDTH*DEPTH-1:0] vec;
  logic                        vec_valid;
  logic [FILT_CNT_WIDTH-1:0]   filt_cnt;
  logic                        all_done;
  logic                        err;

  assign clr     = bus.fcl_rsp_clr_i;
  assign wr      = bus.fcl_rsp_sram_wr_en_i;
  assign rd      = bus.fcl_rsp_sram_rd_en_i;
  assign addr    = bus.fcl_rsp_sram_addr_i;
  assign wr_data = bus.fcl_rsp_wr_data_i;

  assign bus.fcl_rsp_rd_data_o   = rd_data;
  assign bus.fcl_rsp_rd_valid_o  = rd_valid;
  assign bus.fcl_rsp_vec_o       = vec;
  assign bus.fcl_rsp_vec_valid_o = vec_valid;
  assign bus.fcl_rsp_filt_cnt_o  = filt_cnt;
  assign bus.fcl_rsp_all_done_o  = all_done;
  assign bus.fcl_rsp_err_o       = err;

  assign in_range   = (addr <= LAST_ADDR);
  assign dir_switch = ((state == WR) && rd) || ((state == RD) && wr);

  // State and expected-address registers
  always_ff @(posedge fcl_ctrl_clk or posedge fcl_ctrl_rst) begin
    if (fcl_ctrl_rst) begin
      state <= IDLE;
      exp   <= '0;
    end else begin
      state <= state_nxt;
      exp   <= exp_nxt;
    end
  end

  // Next state: any accepted access steers the burst; the last address closes it
  always_comb begin
    state_nxt = state;
    exp_nxt   = exp;
    if (clr) begin
      state_nxt = IDLE;
      exp_nxt   = '0;
    end else if (do_wr || do_rd) begin
      if (addr == LAST_ADDR) begin
        exp_nxt   = '0;
        state_nxt = (do_rd && (filt_cnt == FILT_LAST_M1)) ? DONE : IDLE;
      end else begin
        exp_nxt   = addr + SRAM_CNT_WIDTH'(1);
        state_nxt = do_rd ? RD : WR;
      end
    end else begin
      state_nxt = state;
      exp_nxt   = exp;
    end
  end

  // Access decode and protocol error detection
  always_comb begin
    do_wr         = 1'b0;
    do_rd         = 1'b0;
    burst_rd_done = 1'b0;
    err_set       = 1'b0;
    if (clr) begin
      err_set = 1'b0;
    end else begin
      case (state)
        IDLE, WR, RD: begin
          if (wr && rd) begin
            err_set = 1'b1;
          end else if ((wr || rd) && !in_range) begin
            err_set = 1'b1;
          end else if (wr || rd) begin
            do_wr         = wr;
            do_rd         = rd;
            err_set       = (addr != exp) || dir_switch;
            burst_rd_done = rd && (addr == LAST_ADDR);
          end else begin
            err_set = 1'b0;
          end
        end
        DONE:    err_set = wr || rd;
        default: err_set = 1'b1;
      endcase
    end
  end

  // Weight store: deliberately not reset so a frame restart keeps the weights
  always_ff @(posedge fcl_ctrl_clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (do_wr && (addr == SRAM_CNT_WIDTH'(k))) begin
        mem[k] <= wr_data;
      end
    end
  end

  // Read response, burst packing, filter counting and sticky error
  always_ff @(posedge fcl_ctrl_clk or posedge fcl_ctrl_rst) begin
    if (fcl_ctrl_rst) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      vec       <= '0;
      vec_valid <= 1'b0;
      filt_cnt  <= '0;
      all_done  <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      vec       <= '0;
      vec_valid <= 1'b0;
      filt_cnt  <= '0;
      all_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid  <= do_rd;
      vec_valid <= burst_rd_done;
      for (int k = 0; k < DEPTH; k++) begin
        if (do_rd && (addr == SRAM_CNT_WIDTH'(k))) begin
          rd_data                            <= mem[k];
          vec[k*DATA_WIDTH +: DATA_WIDTH]    <= mem[k];
        end
      end
      if (burst_rd_done) begin
        filt_cnt <= filt_cnt + FILT_CNT_WIDTH'(1);
        if (filt_cnt == FILT_LAST_M1) begin
          all_done <= 1'b1;
        end
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fcl1_sram_rsp.sv
// Directed bench for fcl1_sram_rsp: write/read bursts, frame completion, error cases,
// asynchronous reset and frame clear.
module tb_fcl1_sram_rsp;
  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int NF    = 120;
  localparam int FW    = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [DW-1:0] pat [DEPTH];

  fcl1_sram_rsp_if #(.SRAM_CNT_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                     .FILT_CNT_WIDTH(FW)) bus ();

  fcl1_sram_rsp #(.SRAM_CNT_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
                  .NUM_FILT(NF), .FILT_CNT_WIDTH(FW)) dut (
    .fcl_ctrl_clk (clk),
    .fcl_ctrl_rst (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus.fcl_rsp_sram_rd_en_i = 1'b1;
    bus.fcl_rsp_sram_addr_i  = a;
    cyc();
    bus.fcl_rsp_sram_rd_en_i = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.fcl_rsp_sram_wr_en_i = 1'b1;
    bus.fcl_rsp_sram_addr_i  = a;
    bus.fcl_rsp_wr_data_i    = d;
    cyc();
    bus.fcl_rsp_sram_wr_en_i = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.fcl_rsp_clr_i = 1'b1;
    cyc();
    bus.fcl_rsp_clr_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_data"},   64'(bus.fcl_rsp_rd_data_o),   64'h0);
    chk({tag, "_rd_valid"},  64'(bus.fcl_rsp_rd_valid_o),  64'h0);
    chk({tag, "_vec"},       64'(bus.fcl_rsp_vec_o),       64'h0);
    chk({tag, "_vec_valid"}, 64'(bus.fcl_rsp_vec_valid_o), 64'h0);
    chk({tag, "_filt_cnt"},  64'(bus.fcl_rsp_filt_cnt_o),  64'h0);
    chk({tag, "_all_done"},  64'(bus.fcl_rsp_all_done_o),  64'h0);
    chk({tag, "_err"},       64'(bus.fcl_rsp_err_o),       64'h0);
  endtask

  // Full in-order read burst with up to gapmax idle cycles before each read
  task automatic read_burst(input int gapmax, input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      repeat ($urandom_range(0, gapmax)) cyc();
      rd(AW'(a));
      chk({tag, "_rd_valid"},  64'(bus.fcl_rsp_rd_valid_o),  64'h1);
      chk({tag, "_rd_data"},   64'(bus.fcl_rsp_rd_data_o),   64'(pat[a]));
      chk({tag, "_vec_valid"}, 64'(bus.fcl_rsp_vec_valid_o), 64'(a == DEPTH - 1));
    end
  endtask

  initial begin
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44; pat[4] = 8'h55;
    bus.fcl_rsp_clr_i        = 1'b0;
    bus.fcl_rsp_sram_wr_en_i = 1'b0;
    bus.fcl_rsp_sram_rd_en_i = 1'b0;
    bus.fcl_rsp_sram_addr_i  = 3'd0;
    bus.fcl_rsp_wr_data_i    = 8'h00;

    // reset state
    #2 rst = 1'b1;
    #2 chk_zero("reset");
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // 1: write burst then back-to-back read burst
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), pat[a]);
    chk("t1_wr_filt",  64'(bus.fcl_rsp_filt_cnt_o),  64'h0);
    chk("t1_wr_rdv",   64'(bus.fcl_rsp_rd_valid_o),  64'h0);
    chk("t1_wr_err",   64'(bus.fcl_rsp_err_o),       64'h0);
    read_burst(0, "t1");
    chk("t1_vec",      64'(bus.fcl_rsp_vec_o),       64'h5544332211);
    chk("t1_filt",     64'(bus.fcl_rsp_filt_cnt_o),  64'h1);
    chk("t1_err",      64'(bus.fcl_rsp_err_o),       64'h0);
    cyc();
    chk("t1_rdv_drop", 64'(bus.fcl_rsp_rd_valid_o),  64'h0);
    chk("t1_vv_drop",  64'(bus.fcl_rsp_vec_valid_o), 64'h0);

    // 2: fill the frame with gapped bursts
    for (int b = 2; b <= NF; b++) begin
      read_burst(3, "t2");
      chk("t2_filt", 64'(bus.fcl_rsp_filt_cnt_o), 64'(b));
      chk("t2_done", 64'(bus.fcl_rsp_all_done_o), 64'(b == NF));
    end
    chk("t2_err_pre",  64'(bus.fcl_rsp_err_o),      64'h0);
    rd(3'd0);
    chk("t2_done_rdv", 64'(bus.fcl_rsp_rd_valid_o), 64'h0);
    chk("t2_done_err", 64'(bus.fcl_rsp_err_o),      64'h1);
    chk("t2_done_cnt", 64'(bus.fcl_rsp_filt_cnt_o), 64'd120);
    chk("t2_done_lvl", 64'(bus.fcl_rsp_all_done_o), 64'h1);
    clr_pulse();
    chk_zero("t2_clr");

    // 3: simultaneous write and read strobes
    bus.fcl_rsp_sram_wr_en_i = 1'b1;
    bus.fcl_rsp_sram_rd_en_i = 1'b1;
    bus.fcl_rsp_sram_addr_i  = 3'd2;
    bus.fcl_rsp_wr_data_i    = 8'hAA;
    cyc();
    bus.fcl_rsp_sram_wr_en_i = 1'b0;
    bus.fcl_rsp_sram_rd_en_i = 1'b0;
    chk("t3_err", 64'(bus.fcl_rsp_err_o),      64'h1);
    chk("t3_rdv", 64'(bus.fcl_rsp_rd_valid_o), 64'h0);
    clr_pulse();
    read_burst(0, "t3");
    chk("t3_vec",  64'(bus.fcl_rsp_vec_o),      64'h5544332211);
    chk("t3_err2", 64'(bus.fcl_rsp_err_o),      64'h0);
    chk("t3_filt", 64'(bus.fcl_rsp_filt_cnt_o), 64'h1);

    // 4: out-of-range address, then a burst with a skipped word
    clr_pulse();
    rd(3'd5);
    chk("t4_oor_rdv", 64'(bus.fcl_rsp_rd_valid_o), 64'h0);
    chk("t4_oor_err", 64'(bus.fcl_rsp_err_o),      64'h1);
    clr_pulse();
    rd(3'd0);
    rd(3'd1);
    chk("t4_err_ok",  64'(bus.fcl_rsp_err_o),       64'h0);
    rd(3'd3);
    chk("t4_err_skp", 64'(bus.fcl_rsp_err_o),       64'h1);
    chk("t4_data3",   64'(bus.fcl_rsp_rd_data_o),   64'h44);
    chk("t4_vv3",     64'(bus.fcl_rsp_vec_valid_o), 64'h0);
    rd(3'd4);
    chk("t4_vv4",     64'(bus.fcl_rsp_vec_valid_o), 64'h1);
    chk("t4_data4",   64'(bus.fcl_rsp_rd_data_o),   64'h55);
    chk("t4_filt",    64'(bus.fcl_rsp_filt_cnt_o),  64'h1);
    chk("t4_vec",     64'(bus.fcl_rsp_vec_o),       64'h5544002211);

    // 5: asynchronous reset mid-burst
    clr_pulse();
    rd(3'd0);
    rd(3'd1);
    rd(3'd2);
    chk("t5_rdv_pre", 64'(bus.fcl_rsp_rd_valid_o), 64'h1);
    rst = 1'b1;
    #2 chk_zero("t5_async");
    cyc();
    rst = 1'b0;
    read_burst(0, "t5");
    chk("t5_filt", 64'(bus.fcl_rsp_filt_cnt_o), 64'h1);
    chk("t5_vec",  64'(bus.fcl_rsp_vec_o),      64'h5544332211);
    chk("t5_err",  64'(bus.fcl_rsp_err_o),      64'h0);

    // 6: clear wins over a read strobe in the same cycle
    rd(3'd0);
    rd(3'd1);
    bus.fcl_rsp_clr_i        = 1'b1;
    bus.fcl_rsp_sram_rd_en_i = 1'b1;
    bus.fcl_rsp_sram_addr_i  = 3'd2;
    cyc();
    bus.fcl_rsp_clr_i        = 1'b0;
    bus.fcl_rsp_sram_rd_en_i = 1'b0;
    chk("t6_rdv",  64'(bus.fcl_rsp_rd_valid_o), 64'h0);
    chk("t6_filt", 64'(bus.fcl_rsp_filt_cnt_o), 64'h0);
    chk("t6_err",  64'(bus.fcl_rsp_err_o),      64'h0);
    chk("t6_vec",  64'(bus.fcl_rsp_vec_o),      64'h0);
    read_burst(1, "t6");
    chk("t6_idle_err", 64'(bus.fcl_rsp_err_o),      64'h0);
    chk("t6_filt2",    64'(bus.fcl_rsp_filt_cnt_o), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
